// File: rtl/vproc_burst_engine.sv
// Bus-master engine executing single, burst and idle-tick commands on a VProc-style
// Addr/WE/RD/ack bus, with streamed write data, tagged read return and interrupt capture.
module vproc_burst_engine #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_WIDTH     = 12,
  parameter int BURST_ADDR_INCR = 1,
  parameter int TICK_WIDTH      = 16,
  parameter int INT_WIDTH       = 3
) (
  input  logic                   Clk,
  input  logic                   nReset,
  input  logic                   CmdValid,
  output logic                   CmdReady,
  input  logic [ADDR_WIDTH-1:0]  CmdAddr,
  input  logic                   CmdWE,
  input  logic                   CmdRD,
  input  logic [BURST_WIDTH-1:0] CmdBurst,
  input  logic [TICK_WIDTH-1:0]  CmdTicks,
  input  logic [DATA_WIDTH-1:0]  WData,
  input  logic                   WDataValid,
  output logic                   WDataReady,
  output logic [DATA_WIDTH-1:0]  RData,
  output logic                   RDataValid,
  output logic                   RDataFirst,
  output logic                   RDataLast,
  output logic [ADDR_WIDTH-1:0]  Addr,
  output logic                   WE,
  output logic                   RD,
  output logic [DATA_WIDTH-1:0]  DataOut,
  input  logic [DATA_WIDTH-1:0]  DataIn,
  input  logic                   WRAck,
  input  logic                   RDAck,
  output logic [BURST_WIDTH-1:0] Burst,
  output logic                   BurstFirst,
  output logic                   BurstLast,
  input  logic [INT_WIDTH-1:0]   Interrupt,
  output logic [INT_WIDTH-1:0]   IrqVector,
  output logic                   IrqChange,
  output logic                   Busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_WAITDATA = 2'd2,
    S_TICK     = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  dout_q, dout_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH-1:0] n_q, n_d;
  logic [TICK_WIDTH-1:0]  ticks_q, ticks_d;
  logic [TICK_WIDTH-1:0]  tcnt_q, tcnt_d;
  logic [INT_WIDTH-1:0]   irqv_q, irqv_d;
  logic                   we_q, we_d, rd_q, rd_d;
  logic                   bfirst_q, bfirst_d, blast_q, blast_d;
  logic                   rvalid_q, rvalid_d, rfirst_q, rfirst_d, rlast_q, rlast_d;
  logic                   irqchg_q, irqchg_d, busy_q, busy_d;
  logic                   first_q, first_d;
  logic                   ack_s, wready_s;

  assign ack_s = (we_q && WRAck) || (rd_q && RDAck);

  // Next-state and next-output computation for the command FSM and interrupt sampler
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    rdata_d  = rdata_q;
    burst_d  = burst_q;
    n_d      = n_q;
    ticks_d  = ticks_q;
    tcnt_d   = tcnt_q;
    we_d     = we_q;
    rd_d     = rd_q;
    bfirst_d = bfirst_q;
    blast_d  = blast_q;
    first_d  = first_q;
    rvalid_d = 1'b0;
    rfirst_d = 1'b0;
    rlast_d  = 1'b0;
    wready_s = 1'b0;

    if (Interrupt != irqv_q) begin
      irqv_d   = Interrupt;
      irqchg_d = 1'b1;
    end else begin
      irqv_d   = irqv_q;
      irqchg_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (CmdValid) begin
          addr_d  = CmdAddr;
          burst_d = CmdBurst;
          ticks_d = CmdTicks;
          n_d     = (CmdBurst == '0) ? BURST_WIDTH'(1) : CmdBurst;
          first_d = 1'b1;
          if (CmdWE) begin
            if (WDataValid) begin
              wready_s = 1'b1;
              dout_d   = WData;
              we_d     = 1'b1;
              bfirst_d = (CmdBurst != '0);
              blast_d  = (CmdBurst == BURST_WIDTH'(1));
              state_d  = S_ACCESS;
            end else begin
              state_d = S_WAITDATA;
            end
          end else if (CmdRD) begin
            rd_d     = 1'b1;
            bfirst_d = (CmdBurst != '0);
            blast_d  = (CmdBurst == BURST_WIDTH'(1));
            state_d  = S_ACCESS;
          end else if (CmdTicks != '0) begin
            tcnt_d  = CmdTicks;
            state_d = S_TICK;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (ack_s) begin
          first_d = 1'b0;
          if (rd_q) begin
            rdata_d  = DataIn;
            rvalid_d = 1'b1;
            rfirst_d = bfirst_q;
            rlast_d  = (n_q == BURST_WIDTH'(1));
          end else begin
            rdata_d = rdata_q;
          end
          if (n_q > BURST_WIDTH'(1)) begin
            n_d      = n_q - BURST_WIDTH'(1);
            addr_d   = addr_q + ADDR_WIDTH'(BURST_ADDR_INCR);
            bfirst_d = 1'b0;
            blast_d  = (burst_q != '0) && (n_q == BURST_WIDTH'(2));
            // A write burst stalls in WAITDATA when the next word is not ready
            if (we_q && !WDataValid) begin
              we_d    = 1'b0;
              blast_d = 1'b0;
              state_d = S_WAITDATA;
            end else if (we_q) begin
              wready_s = 1'b1;
              dout_d   = WData;
            end else begin
              rd_d = 1'b1;
            end
          end else begin
            we_d     = 1'b0;
            rd_d     = 1'b0;
            bfirst_d = 1'b0;
            blast_d  = 1'b0;
            if (ticks_q != '0) begin
              tcnt_d  = ticks_q;
              state_d = S_TICK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_WAITDATA: begin
        wready_s = WDataValid;
        if (WDataValid) begin
          dout_d   = WData;
          we_d     = 1'b1;
          bfirst_d = (burst_q != '0) && first_q;
          blast_d  = (burst_q != '0) && (n_q == BURST_WIDTH'(1));
          state_d  = S_ACCESS;
        end else begin
          we_d = 1'b0;
        end
      end
      S_TICK: begin
        if (tcnt_q <= TICK_WIDTH'(1)) begin
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q - TICK_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        we_d    = 1'b0;
        rd_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered-output flops with asynchronous clear
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      dout_q   <= '0;
      rdata_q  <= '0;
      burst_q  <= '0;
      n_q      <= '0;
      ticks_q  <= '0;
      tcnt_q   <= '0;
      irqv_q   <= '0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      bfirst_q <= 1'b0;
      blast_q  <= 1'b0;
      first_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rfirst_q <= 1'b0;
      rlast_q  <= 1'b0;
      irqchg_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdata_q  <= rdata_d;
      burst_q  <= burst_d;
      n_q      <= n_d;
      ticks_q  <= ticks_d;
      tcnt_q   <= tcnt_d;
      irqv_q   <= irqv_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      bfirst_q <= bfirst_d;
      blast_q  <= blast_d;
      first_q  <= first_d;
      rvalid_q <= rvalid_d;
      rfirst_q <= rfirst_d;
      rlast_q  <= rlast_d;
      irqchg_q <= irqchg_d;
      busy_q   <= busy_d;
    end
  end

  assign CmdReady   = (state_q == S_IDLE);
  assign WDataReady = wready_s;
  assign Addr       = addr_q;
  assign WE         = we_q;
  assign RD         = rd_q;
  assign DataOut    = dout_q;
  assign Burst      = burst_q;
  assign BurstFirst = bfirst_q;
  assign BurstLast  = blast_q;
  assign RData      = rdata_q;
  assign RDataValid = rvalid_q;
  assign RDataFirst = rfirst_q;
  assign RDataLast  = rlast_q;
  assign IrqVector  = irqv_q;
  assign IrqChange  = irqchg_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_vproc_burst_engine.sv
// Directed self-checking bench for vproc_burst_engine; inputs change on the falling
// edge and outputs are sampled there, away from the rising active edge.
module tb_vproc_burst_engine;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        CmdValid, CmdReady, CmdWE, CmdRD;
  logic [31:0] CmdAddr;
  logic [11:0] CmdBurst;
  logic [15:0] CmdTicks;
  logic [31:0] WData;
  logic        WDataValid, WDataReady;
  logic [31:0] RData;
  logic        RDataValid, RDataFirst, RDataLast;
  logic [31:0] Addr, DataOut, DataIn;
  logic        WE, RD, WRAck, RDAck;
  logic [11:0] Burst;
  logic        BurstFirst, BurstLast;
  logic [2:0]  Interrupt, IrqVector;
  logic        IrqChange, Busy;
  logic        din_follow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  // Memory model: read data equals the bus address
  assign DataIn = din_follow ? Addr : 32'h0;

  vproc_burst_engine dut (
    .Clk(Clk), .nReset(nReset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdAddr(CmdAddr), .CmdWE(CmdWE), .CmdRD(CmdRD), .CmdBurst(CmdBurst),
    .CmdTicks(CmdTicks), .WData(WData), .WDataValid(WDataValid),
    .WDataReady(WDataReady), .RData(RData), .RDataValid(RDataValid),
    .RDataFirst(RDataFirst), .RDataLast(RDataLast), .Addr(Addr), .WE(WE),
    .RD(RD), .DataOut(DataOut), .DataIn(DataIn), .WRAck(WRAck), .RDAck(RDAck),
    .Burst(Burst), .BurstFirst(BurstFirst), .BurstLast(BurstLast),
    .Interrupt(Interrupt), .IrqVector(IrqVector), .IrqChange(IrqChange),
    .Busy(Busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic cmd(input logic [31:0] a, input logic we, input logic rd,
                     input logic [11:0] b, input logic [15:0] t);
    CmdValid = 1'b1; CmdAddr = a; CmdWE = we; CmdRD = rd; CmdBurst = b; CmdTicks = t;
  endtask

  task automatic cmd_off();
    CmdValid = 1'b0; CmdWE = 1'b0; CmdRD = 1'b0;
  endtask

  initial begin
    nReset = 1'b0; cmd_off(); CmdAddr = 32'h0; CmdBurst = 12'h0; CmdTicks = 16'h0;
    WData = 32'h0; WDataValid = 1'b0; WRAck = 1'b0; RDAck = 1'b0;
    Interrupt = 3'd0; din_follow = 1'b1;
    repeat (2) @(negedge Clk);
    check_eq("rst_we", {63'h0, WE}, 64'h0);
    check_eq("rst_rd", {63'h0, RD}, 64'h0);
    check_eq("rst_addr", {32'h0, Addr}, 64'h0);
    check_eq("rst_busy", {63'h0, Busy}, 64'h0);
    check_eq("rst_rvalid", {63'h0, RDataValid}, 64'h0);
    check_eq("rst_irqv", {61'h0, IrqVector}, 64'h0);
    nReset = 1'b1;
    step();
    check_eq("idle_ready", {63'h0, CmdReady}, 64'h1);

    // Single write with ack one cycle after WE
    cmd(32'h100, 1'b1, 1'b0, 12'd0, 16'd0);
    WData = 32'hDEADBEEF; WDataValid = 1'b1;
    #1 check_eq("sw_wready", {63'h0, WDataReady}, 64'h1);
    step();
    cmd_off(); WDataValid = 1'b0;
    check_eq("sw_we1", {63'h0, WE}, 64'h1);
    check_eq("sw_addr", {32'h0, Addr}, 64'h100);
    check_eq("sw_dout", {32'h0, DataOut}, 64'hDEADBEEF);
    check_eq("sw_burst", {52'h0, Burst}, 64'h0);
    check_eq("sw_bflags", {62'h0, BurstFirst, BurstLast}, 64'h0);
    check_eq("sw_cmdready", {63'h0, CmdReady}, 64'h0);
    step();
    check_eq("sw_we2", {63'h0, WE}, 64'h1);
    WRAck = 1'b1;
    step();
    WRAck = 1'b0;
    check_eq("sw_we_done", {63'h0, WE}, 64'h0);
    check_eq("sw_ready_done", {63'h0, CmdReady}, 64'h1);
    check_eq("sw_busy_done", {63'h0, Busy}, 64'h0);

    // Read burst of 4 with zero-wait ack
    cmd(32'h200, 1'b0, 1'b1, 12'd4, 16'd0);
    RDAck = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      cmd_off();
      if (k <= 4) begin
        check_eq($sformatf("rb_rd%0d", k), {63'h0, RD}, 64'h1);
        check_eq($sformatf("rb_addr%0d", k), {32'h0, Addr}, 64'h200 + 64'(k - 1));
        check_eq($sformatf("rb_bf%0d", k), {63'h0, BurstFirst}, {63'h0, k == 1});
        check_eq($sformatf("rb_bl%0d", k), {63'h0, BurstLast}, {63'h0, k == 4});
      end else begin
        check_eq($sformatf("rb_rd_off%0d", k), {63'h0, RD}, 64'h0);
      end
      if (k >= 2 && k <= 5) begin
        check_eq($sformatf("rb_rv%0d", k), {63'h0, RDataValid}, 64'h1);
        check_eq($sformatf("rb_rdata%0d", k), {32'h0, RData}, 64'h200 + 64'(k - 2));
        check_eq($sformatf("rb_rf%0d", k), {63'h0, RDataFirst}, {63'h0, k == 2});
        check_eq($sformatf("rb_rl%0d", k), {63'h0, RDataLast}, {63'h0, k == 5});
      end else if (k == 6) begin
        check_eq("rb_rv_end", {63'h0, RDataValid}, 64'h0);
      end
    end
    RDAck = 1'b0;

    // Write burst of 3 with a 2-cycle data gap after the first word
    cmd(32'h300, 1'b1, 1'b0, 12'd3, 16'd0);
    WData = 32'hA0; WDataValid = 1'b1; WRAck = 1'b1;
    step();
    cmd_off(); WDataValid = 1'b0;
    check_eq("wb_w0", {32'h0, DataOut}, 64'hA0);
    check_eq("wb_a0", {32'h0, Addr}, 64'h300);
    check_eq("wb_bf0", {63'h0, BurstFirst}, 64'h1);
    step();
    check_eq("wb_gap1_we", {63'h0, WE}, 64'h0);
    check_eq("wb_gap1_addr", {32'h0, Addr}, 64'h301);
    check_eq("wb_gap1_wready", {63'h0, WDataReady}, 64'h0);
    step();
    check_eq("wb_gap2_we", {63'h0, WE}, 64'h0);
    check_eq("wb_gap2_addr", {32'h0, Addr}, 64'h301);
    WData = 32'hA1; WDataValid = 1'b1;
    #1 check_eq("wb_wait_wready", {63'h0, WDataReady}, 64'h1);
    step();
    WData = 32'hA2;
    check_eq("wb_w1_we", {63'h0, WE}, 64'h1);
    check_eq("wb_w1", {32'h0, DataOut}, 64'hA1);
    check_eq("wb_a1", {32'h0, Addr}, 64'h301);
    check_eq("wb_bf1", {63'h0, BurstFirst}, 64'h0);
    step();
    WDataValid = 1'b0;
    check_eq("wb_w2_we", {63'h0, WE}, 64'h1);
    check_eq("wb_w2", {32'h0, DataOut}, 64'hA2);
    check_eq("wb_a2", {32'h0, Addr}, 64'h302);
    check_eq("wb_bl2", {63'h0, BurstLast}, 64'h1);
    step();
    WRAck = 1'b0;
    check_eq("wb_done_we", {63'h0, WE}, 64'h0);
    check_eq("wb_done_busy", {63'h0, Busy}, 64'h0);

    // Pure idle-tick command of 5 cycles
    cmd(32'h0, 1'b0, 1'b0, 12'd0, 16'd5);
    for (int k = 1; k <= 6; k++) begin
      step();
      cmd_off();
      check_eq($sformatf("tk_busy%0d", k), {63'h0, Busy}, {63'h0, k <= 5});
      check_eq($sformatf("tk_ready%0d", k), {63'h0, CmdReady}, {63'h0, k == 6});
      check_eq($sformatf("tk_strobe%0d", k), {62'h0, WE, RD}, 64'h0);
    end

    // Single read followed by 2 idle cycles
    cmd(32'h40, 1'b0, 1'b1, 12'd0, 16'd2);
    RDAck = 1'b1;
    step();
    cmd_off();
    check_eq("rt_rd", {63'h0, RD}, 64'h1);
    step();
    RDAck = 1'b0;
    check_eq("rt_rdata", {32'h0, RData}, 64'h40);
    check_eq("rt_rlast", {63'h0, RDataLast}, 64'h1);
    check_eq("rt_rd_off", {63'h0, RD}, 64'h0);
    check_eq("rt_tick1", {62'h0, Busy, CmdReady}, 64'h2);
    step();
    check_eq("rt_tick2", {62'h0, Busy, CmdReady}, 64'h2);
    step();
    check_eq("rt_idle", {62'h0, Busy, CmdReady}, 64'h1);

    // Interrupt 0->3->3->0
    Interrupt = 3'd3;
    step();
    check_eq("irq_p1", {60'h0, IrqChange, IrqVector}, 64'hB);
    step();
    check_eq("irq_hold", {60'h0, IrqChange, IrqVector}, 64'h3);
    Interrupt = 3'd0;
    step();
    check_eq("irq_p2", {60'h0, IrqChange, IrqVector}, 64'h8);
    step();
    check_eq("irq_quiet", {63'h0, IrqChange}, 64'h0);

    // One-cycle interrupt blip while a write is stalled waiting for ack
    cmd(32'h500, 1'b1, 1'b0, 12'd0, 16'd0);
    WData = 32'h55; WDataValid = 1'b1;
    step();
    cmd_off(); WDataValid = 1'b0; Interrupt = 3'd5;
    step();
    Interrupt = 3'd0;
    check_eq("irqs_on", {60'h0, IrqChange, IrqVector}, 64'hD);
    check_eq("irqs_we", {63'h0, WE}, 64'h1);
    step();
    WRAck = 1'b1;
    check_eq("irqs_off", {60'h0, IrqChange, IrqVector}, 64'h8);
    check_eq("irqs_we2", {63'h0, WE}, 64'h1);
    step();
    WRAck = 1'b0;
    check_eq("irqs_done", {62'h0, WE, IrqChange}, 64'h0);

    // Asynchronous reset while word 2 of a 4-word read burst is on the bus
    cmd(32'h600, 1'b0, 1'b1, 12'd4, 16'd0);
    RDAck = 1'b1;
    step();
    cmd_off();
    step();
    check_eq("mr_rd", {63'h0, RD}, 64'h1);
    check_eq("mr_addr", {32'h0, Addr}, 64'h601);
    #2 nReset = 1'b0;
    #1;
    check_eq("mr_strobes", {60'h0, WE, RD, BurstFirst, BurstLast}, 64'h0);
    check_eq("mr_addr0", {32'h0, Addr}, 64'h0);
    check_eq("mr_busy", {63'h0, Busy}, 64'h0);
    check_eq("mr_burst", {52'h0, Burst}, 64'h0);
    @(negedge Clk);
    nReset = 1'b1;
    cmd(32'h700, 1'b0, 1'b1, 12'd0, 16'd0);
    step();
    cmd_off();
    check_eq("pr_rd", {63'h0, RD}, 64'h1);
    check_eq("pr_addr", {32'h0, Addr}, 64'h700);
    step();
    RDAck = 1'b0;
    check_eq("pr_rdata", {32'h0, RData}, 64'h700);
    check_eq("pr_rvalid", {63'h0, RDataValid}, 64'h1);
    check_eq("pr_idle", {62'h0, RD, CmdReady}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
